// File: rtl/neuron_accumulate_if.sv
// Handshake bundle between the product source, the neuron block and the consumer.
// slave: neuron side (takes products, drives activations); master: the surrounding logic.
interface neuron_accumulate_if;
    logic        prod_valid;
    logic [15:0] prod;
    logic        prod_ready;
    logic [15:0] bias;
    logic        out_valid;
    logic        out_ready;
    logic [7:0]  out_data;
    logic        out_sat;

    modport master (
        output prod_valid,
        output prod,
        output bias,
        output out_ready,
        input  prod_ready,
        input  out_valid,
        input  out_data,
        input  out_sat
    );

    modport slave (
        input  prod_valid,
        input  prod,
        input  bias,
        input  out_ready,
        output prod_ready,
        output out_valid,
        output out_data,
        output out_sat
    );
endinterface

// File: rtl/neuron_accumulate.sv
// Neuron accumulator: sums bias + N_TERMS unsigned products, then ReLU-quantises to 8 bits.
// Ports: clk, reset (async active-low), bus (slave: prod/bias in, out_data/out_sat out).
module neuron_accumulate #(
    parameter int N_TERMS = 8,
    parameter int ACC_W   = 24,
    parameter int SHIFT   = 8
) (
    input logic                clk,
    input logic                reset,
    neuron_accumulate_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE,
        ACCUM,
        ACT,
        OUT
    } state_t;

    localparam logic [7:0] LAST = 8'(N_TERMS);

    state_t                  state_q, state_d;
    logic signed [ACC_W-1:0] acc_q, acc_d;
    logic [7:0]              cnt_q, cnt_d;
    logic                    prod_ready_q, prod_ready_d;
    logic                    out_valid_q, out_valid_d;
    logic [7:0]              out_data_q, out_data_d;
    logic                    out_sat_q, out_sat_d;

    logic                    xfer;
    logic signed [ACC_W-1:0] prod_ext;
    logic signed [ACC_W-1:0] bias_ext;
    logic signed [ACC_W-1:0] shifted;
    logic                    over;

    assign xfer     = bus.prod_valid & prod_ready_q;
    assign prod_ext = {{(ACC_W-16){1'b0}}, bus.prod};
    assign bias_ext = {{(ACC_W-16){bus.bias[15]}}, bus.bias};
    assign shifted  = acc_q >>> SHIFT;
    assign over     = |shifted[ACC_W-1:8];

    always_comb begin
        state_d      = state_q;
        acc_d        = acc_q;
        cnt_d        = cnt_q;
        prod_ready_d = prod_ready_q;
        out_valid_d  = out_valid_q;
        out_data_d   = out_data_q;
        out_sat_d    = out_sat_q;
        unique case (state_q)
            IDLE: begin
                if (xfer) begin
                    acc_d   = bias_ext + prod_ext;
                    cnt_d   = 8'd1;
                    state_d = ACCUM;
                end
                prod_ready_d = (cnt_d != LAST);
            end
            ACCUM: begin
                // The edge that fills the count closes prod_ready; the
                // following cycle hands the settled sum to ACT.
                if (cnt_q == LAST) begin
                    state_d = ACT;
                end else if (xfer) begin
                    acc_d = acc_q + prod_ext;
                    cnt_d = cnt_q + 8'd1;
                end
                prod_ready_d = (cnt_d != LAST);
            end
            ACT: begin
                if (acc_q[ACC_W-1]) begin
                    out_data_d = 8'd0;
                    out_sat_d  = 1'b0;
                end else begin
                    out_data_d = over ? 8'hff : shifted[7:0];
                    out_sat_d  = over;
                end
                out_valid_d  = 1'b1;
                prod_ready_d = 1'b0;
                state_d      = OUT;
            end
            OUT: begin
                prod_ready_d = 1'b0;
                if (bus.out_ready) begin
                    out_valid_d  = 1'b0;
                    cnt_d        = 8'd0;
                    prod_ready_d = 1'b1;
                    state_d      = IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= IDLE;
            acc_q        <= '0;
            cnt_q        <= 8'd0;
            prod_ready_q <= 1'b0;
            out_valid_q  <= 1'b0;
            out_data_q   <= 8'd0;
            out_sat_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            acc_q        <= acc_d;
            cnt_q        <= cnt_d;
            prod_ready_q <= prod_ready_d;
            out_valid_q  <= out_valid_d;
            out_data_q   <= out_data_d;
            out_sat_q    <= out_sat_d;
        end
    end

    assign bus.prod_ready = prod_ready_q;
    assign bus.out_valid  = out_valid_q;
    assign bus.out_data   = out_data_q;
    assign bus.out_sat    = out_sat_q;

endmodule

// File: tb/tb_neuron_accumulate.sv
// Directed bench for neuron_accumulate (N_TERMS=8, ACC_W=24, SHIFT=8).
// Drives and samples on the falling edge; DUT state changes on the rising edge.
module tb_neuron_accumulate;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   cyc   = 0;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    neuron_accumulate_if bus ();

    neuron_accumulate #(
        .N_TERMS(8),
        .ACC_W  (24),
        .SHIFT  (8)
    ) dut (
        .clk  (clk),
        .reset(rst_n),
        .bus  (bus)
    );

    // Offer one product until it is taken; returns the edge index it went in on.
    task automatic push(input logic [15:0] p, input logic [15:0] b, output int e);
        logic rdy;
        e = -1;
        bus.prod_valid = 1'b1;
        bus.prod = p;
        bus.bias = b;
        for (int i = 0; i < 40; i++) begin
            rdy = bus.prod_ready;
            @(negedge clk);
            if (rdy) begin
                e = cyc;
                break;
            end
        end
        bus.prod_valid = 1'b0;
        if (e < 0) begin
            checks++;
            errors++;
            $display("FAIL push_timeout: product %0d not accepted in 40 cycles", p);
        end
    endtask

    task automatic push_n(input int n, input logic [15:0] p, input logic [15:0] b, output int e);
        for (int i = 0; i < n; i++) push(p, b, e);
    endtask

    task automatic wait_out(output int e);
        e = -1;
        for (int i = 0; i < 30; i++) begin
            if (bus.out_valid) begin
                e = cyc;
                break;
            end
            @(negedge clk);
        end
        if (e < 0) begin
            checks++;
            errors++;
            $display("FAIL out_timeout: out_valid never rose within 30 cycles");
        end
    endtask

    task automatic pop();
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.out_ready = 1'b0;
    endtask

    task automatic test_reset();
        #2;
        checks++;
        if (bus.prod_ready !== 1'b0) begin
            errors++;
            $display("FAIL rst_prod_ready: got %b want 0", bus.prod_ready);
        end
        checks++;
        if (bus.out_valid !== 1'b0) begin
            errors++;
            $display("FAIL rst_out_valid: got %b want 0", bus.out_valid);
        end
        checks++;
        if (bus.out_data !== 8'd0) begin
            errors++;
            $display("FAIL rst_out_data: got %0d want 0", bus.out_data);
        end
        checks++;
        if (bus.out_sat !== 1'b0) begin
            errors++;
            $display("FAIL rst_out_sat: got %b want 0", bus.out_sat);
        end
        repeat (2) @(negedge clk);
        checks++;
        if (bus.prod_ready !== 1'b0) begin
            errors++;
            $display("FAIL rst_held_ready: got %b want 0", bus.prod_ready);
        end
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (bus.prod_ready !== 1'b1) begin
            errors++;
            $display("FAIL rst_release_ready: got %b want 1", bus.prod_ready);
        end
    endtask

    task automatic test_nominal();
        int t, o;
        push_n(8, 16'd256, 16'd0, t);
        wait_out(o);
        checks++;
        if (o !== t + 2) begin
            errors++;
            $display("FAIL nom_latency: out_valid at edge %0d want %0d", o, t + 2);
        end
        checks++;
        if (bus.out_data !== 8'd8 || bus.out_sat !== 1'b0) begin
            errors++;
            $display("FAIL nom_data: got %0d/%b want 8/0", bus.out_data, bus.out_sat);
        end
        checks++;
        if (bus.prod_ready !== 1'b0) begin
            errors++;
            $display("FAIL nom_ready_out: got %b want 0", bus.prod_ready);
        end
        pop();
        checks++;
        if (bus.out_valid !== 1'b0 || bus.prod_ready !== 1'b1) begin
            errors++;
            $display("FAIL nom_pop: valid/ready %b/%b want 0/1", bus.out_valid, bus.prod_ready);
        end
    endtask

    task automatic test_negative();
        int t, o;
        push_n(8, 16'd100, 16'h8000, t);
        wait_out(o);
        checks++;
        if (bus.out_data !== 8'd0 || bus.out_sat !== 1'b0) begin
            errors++;
            $display("FAIL neg_clamp: got %0d/%b want 0/0", bus.out_data, bus.out_sat);
        end
        pop();
    endtask

    task automatic test_saturate();
        int t, o;
        push_n(8, 16'd65025, 16'd0, t);
        wait_out(o);
        checks++;
        if (bus.out_data !== 8'd255 || bus.out_sat !== 1'b1) begin
            errors++;
            $display("FAIL sat: got %0d/%b want 255/1", bus.out_data, bus.out_sat);
        end
        pop();
    endtask

    task automatic test_backpressure();
        int t, o;
        int bad;
        // bias 256 + 8*256 = 2304 -> 9
        push_n(8, 16'd256, 16'h0100, t);
        wait_out(o);
        bad = 0;
        for (int i = 0; i < 5; i++) begin
            bus.prod_valid = i[0];
            bus.prod = 16'd1234;
            @(negedge clk);
            if (bus.out_valid !== 1'b1 || bus.out_data !== 8'd9 ||
                bus.out_sat !== 1'b0 || bus.prod_ready !== 1'b0) bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL bp_stable: %0d unstable cycles want 0", bad);
        end
        // Output handshake and a product offered together: only the output goes.
        bus.prod_valid = 1'b1;
        bus.prod = 16'hffff;
        pop();
        bus.prod_valid = 1'b0;
        checks++;
        if (bus.out_valid !== 1'b0 || bus.prod_ready !== 1'b1) begin
            errors++;
            $display("FAIL bp_release: valid/ready %b/%b want 0/1", bus.out_valid, bus.prod_ready);
        end
        push_n(8, 16'd256, 16'd0, t);
        wait_out(o);
        checks++;
        if (bus.out_data !== 8'd8) begin
            errors++;
            $display("FAIL bp_next: got %0d want 8", bus.out_data);
        end
        pop();
    endtask

    task automatic test_bubbles();
        int t, o;
        for (int i = 0; i < 8; i++) begin
            push(16'd256, (i == 0) ? 16'd0 : 16'h7fff, t);
            @(negedge clk);
        end
        wait_out(o);
        checks++;
        if (bus.out_data !== 8'd8 || bus.out_sat !== 1'b0) begin
            errors++;
            $display("FAIL bubble_data: got %0d/%b want 8/0", bus.out_data, bus.out_sat);
        end
        checks++;
        if (o !== t + 2) begin
            errors++;
            $display("FAIL bubble_latency: edge %0d want %0d", o, t + 2);
        end
        pop();
    endtask

    task automatic test_back_to_back();
        int seen;
        int e0, e1;
        seen = 0;
        e0 = -1;
        e1 = -1;
        bus.out_ready = 1'b1;
        bus.prod_valid = 1'b1;
        bus.prod = 16'd256;
        bus.bias = 16'd0;
        for (int i = 0; i < 60 && seen < 2; i++) begin
            @(negedge clk);
            if (bus.out_valid) begin
                if (seen == 0) e0 = cyc;
                else e1 = cyc;
                seen++;
                checks++;
                if (bus.out_data !== 8'd8) begin
                    errors++;
                    $display("FAIL b2b_data: got %0d want 8", bus.out_data);
                end
            end
        end
        bus.prod_valid = 1'b0;
        @(negedge clk);
        bus.out_ready = 1'b0;
        checks++;
        if (seen != 2 || e1 - e0 != 11) begin
            errors++;
            $display("FAIL b2b_period: %0d results, period %0d want 2, 11", seen, e1 - e0);
        end
    endtask

    task automatic test_reset_mid();
        int t, o;
        int extra;
        push_n(5, 16'd256, 16'd0, t);
        rst_n = 1'b0;
        #1;
        checks++;
        if (bus.out_valid !== 1'b0 || bus.out_data !== 8'd0 || bus.prod_ready !== 1'b0) begin
            errors++;
            $display("FAIL mid_accum_rst: v/d/r %b/%0d/%b want 0/0/0",
                     bus.out_valid, bus.out_data, bus.prod_ready);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        push_n(8, 16'd65025, 16'd0, t);
        wait_out(o);
        rst_n = 1'b0;
        #1;
        checks++;
        if (bus.out_valid !== 1'b0 || bus.out_data !== 8'd0 || bus.out_sat !== 1'b0) begin
            errors++;
            $display("FAIL mid_out_rst: v/d/s %b/%0d/%b want 0/0/0",
                     bus.out_valid, bus.out_data, bus.out_sat);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        push_n(8, 16'd256, 16'd0, t);
        wait_out(o);
        checks++;
        if (bus.out_data !== 8'd8 || o !== t + 2) begin
            errors++;
            $display("FAIL mid_fresh: got %0d at edge %0d want 8 at %0d", bus.out_data, o, t + 2);
        end
        pop();
        extra = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (bus.out_valid) extra++;
        end
        checks++;
        if (extra != 0) begin
            errors++;
            $display("FAIL mid_single: %0d extra valid cycles want 0", extra);
        end
    endtask

    initial begin
        bus.prod_valid = 1'b0;
        bus.prod = 16'd0;
        bus.bias = 16'd0;
        bus.out_ready = 1'b0;
        test_reset();
        test_nominal();
        test_negative();
        test_saturate();
        test_backpressure();
        test_bubbles();
        test_back_to_back();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
